// File: rtl/mmse_ram_sched.sv
// Single-port RAM scheduler for one slot: MMSE fill, then averaging, then equalizer reads.
// The write counter walks the MMSE region and then the averaged region, which sits right after it.
module mmse_ram_sched #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MMSE_DEPTH = 576,
  parameter int AVG_DEPTH  = 240
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mmse_vld,
  input  logic [RAM_WIDTH-1:0]  mmse_din,
  output logic                  mmse_rdy,
  input  logic                  avg_rd_req,
  input  logic [ADDR_WIDTH-1:0] avg_rd_addr,
  output logic                  avg_rd_gnt,
  input  logic                  avg_wr_vld,
  input  logic [RAM_WIDTH-1:0]  avg_din,
  output logic                  avg_wr_rdy,
  input  logic                  eq_rd_req,
  input  logic [ADDR_WIDTH-1:0] eq_rd_addr,
  output logic                  eq_rd_gnt,
  input  logic                  eq_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]  ram_din,
  output logic                  ram_wre,
  input  logic [RAM_WIDTH-1:0]  ram_dout,
  output logic                  avg_rd_dvld,
  output logic                  eq_rd_dvld,
  output logic [RAM_WIDTH-1:0]  avg_rd_data,
  output logic [RAM_WIDTH-1:0]  eq_rd_data,
  output logic [1:0]            phase,
  output logic                  addr_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, AVG = 2'd2, EQ = 2'd3} state_t;

  localparam logic [ADDR_WIDTH:0]   MMSE_END  = (ADDR_WIDTH+1)'(MMSE_DEPTH);
  localparam logic [ADDR_WIDTH:0]   EQ_END    = (ADDR_WIDTH+1)'(MMSE_DEPTH + AVG_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MMSE_LAST = ADDR_WIDTH'(MMSE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] AVG_FIRST = ADDR_WIDTH'(MMSE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] AVG_LAST  = ADDR_WIDTH'(MMSE_DEPTH + AVG_DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_cnt, cnt_nxt;
  logic                  err_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      avg_rd_dvld <= 1'b0;
      eq_rd_dvld  <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_cnt      <= cnt_nxt;
      avg_rd_dvld <= avg_rd_gnt;
      eq_rd_dvld  <= eq_rd_gnt;
      addr_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = wr_cnt;
    mmse_rdy   = 1'b0;
    avg_wr_rdy = 1'b0;
    avg_rd_gnt = 1'b0;
    eq_rd_gnt  = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    ram_wre    = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
      end
      FILL: begin
        mmse_rdy = 1'b1;
        if (mmse_vld) begin
          ram_wre  = 1'b1;
          ram_din  = mmse_din;
          ram_addr = wr_cnt;
          if (wr_cnt == MMSE_LAST) begin
            state_nxt = AVG;
            cnt_nxt   = AVG_FIRST;
          end else begin
            cnt_nxt = wr_cnt + 1'b1;
          end
        end
      end
      AVG: begin
        avg_wr_rdy = 1'b1;
        // averaged writes win the port; a colliding read must retry
        if (avg_wr_vld) begin
          ram_wre  = 1'b1;
          ram_din  = avg_din;
          ram_addr = wr_cnt;
          if (wr_cnt == AVG_LAST) state_nxt = EQ;
          else                    cnt_nxt   = wr_cnt + 1'b1;
        end else if (avg_rd_req) begin
          if ({1'b0, avg_rd_addr} < MMSE_END) begin
            avg_rd_gnt = 1'b1;
            ram_addr   = avg_rd_addr;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      EQ: begin
        if (eq_rd_req) begin
          if ({1'b0, eq_rd_addr} < EQ_END) begin
            eq_rd_gnt = 1'b1;
            ram_addr  = eq_rd_addr;
          end else begin
            err_nxt = 1'b1;
          end
        end
        if (eq_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign phase       = state;
  assign avg_rd_data = avg_rd_dvld ? ram_dout : '0;
  assign eq_rd_data  = eq_rd_dvld  ? ram_dout : '0;
endmodule

// File: doc/mmse_ram_sched.md
MMSE_RAM_SCHED -- requirements
Module: mmse_ram_sched

Interface
REQ-001 Parameters SHALL be: RAM_WIDTH, default 32, RAM data width; ADDR_WIDTH, default 10, RAM address width; MMSE_DEPTH, default 576, MMSE region size; AVG_DEPTH, default 240, averaged region size.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse, begins a slot.
- mmse_vld  in  1  MMSE write sample valid.
- mmse_din  in  RAM_WIDTH  MMSE write data.
- mmse_rdy  out  1  MMSE write accepted.
- avg_rd_req  in  1  averager read request.
- avg_rd_addr  in  ADDR_WIDTH  averager read address.
- avg_rd_gnt  out  1  averager read granted.
- avg_wr_vld  in  1  averaged result valid.
- avg_din  in  RAM_WIDTH  averaged result data.
- avg_wr_rdy  out  1  averaged write accepted.
- eq_rd_req  in  1  equalizer read request.
- eq_rd_addr  in  ADDR_WIDTH  equalizer read address.
- eq_rd_gnt  out  1  equalizer read granted.
- eq_done  in  1  pulse, equalizer finished.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  RAM_WIDTH  RAM write data.
- ram_wre  out  1  RAM write enable.
- ram_dout  in  RAM_WIDTH  RAM read data, valid one cycle after address.
- avg_rd_dvld / eq_rd_dvld  out  1  read data valid to averager / equalizer.
- avg_rd_data / eq_rd_data  out  RAM_WIDTH  ram_dout routed to that requester.
- phase  out  2  0=IDLE, 1=FILL, 2=AVG, 3=EQ.
- addr_err  out  1  one-cycle pulse, out-of-region request rejected.

Function
REQ-003 The FSM SHALL have states IDLE, FILL, AVG and EQ, with phase equal to the current state encoding.
REQ-004 IDLE->FILL SHALL occur on start; start in any other state SHALL be ignored.
REQ-005 In FILL, mmse_rdy SHALL be 1, and each mmse_vld cycle SHALL drive ram_wre=1, ram_din=mmse_din and ram_addr=wr counter, counting 0..MMSE_DEPTH-1.
REQ-006 On the MMSE_DEPTH-th accepted write, the FSM SHALL go to AVG and load the wr counter with MMSE_DEPTH.
REQ-007 In AVG, avg_wr_vld SHALL have priority: ram_wre=1, ram_din=avg_din, ram_addr=wr counter (MMSE_DEPTH..MMSE_DEPTH+AVG_DEPTH-1), avg_wr_rdy=1 and avg_rd_gnt=0.
REQ-008 In AVG without avg_wr_vld, avg_rd_req SHALL be granted only when avg_rd_addr < MMSE_DEPTH; in that case ram_addr=avg_rd_addr and ram_wre=0.
REQ-009 An avg_rd_req with avg_rd_addr >= MMSE_DEPTH SHALL not be granted and SHALL pulse addr_err.
REQ-010 On the AVG_DEPTH-th averaged write, the FSM SHALL go to EQ.
REQ-011 In EQ, eq_rd_req SHALL be granted every cycle with eq_rd_addr < MMSE_DEPTH+AVG_DEPTH, driving ram_addr=eq_rd_addr and ram_wre=0; an address outside that range SHALL not be granted and SHALL pulse addr_err.
REQ-012 eq_done in EQ SHALL return the FSM to IDLE; eq_done in any other state SHALL be ignored.
REQ-013 Read latency SHALL be 1: the cycle after a grant, the matching *_rd_dvld=1 and *_rd_data=ram_dout; a grant in the last EQ cycle SHALL still deliver its dvld.
REQ-014 Requests from non-owning requesters SHALL be ignored (gnt/rdy=0) with no addr_err: mmse in AVG/EQ/IDLE, avg in FILL/EQ/IDLE, eq outside EQ.
REQ-015 ram_wre SHALL be 0 in every cycle without an accepted write; at most one RAM access SHALL occur per cycle.
REQ-016 Handshake outputs (rdy, gnt, ram_*) SHALL be combinational from state and requests; dvld, data-select and addr_err SHALL be registered.

Reset
REQ-017 On rst=0, asynchronously: state=IDLE, wr counter=0, all gnt/rdy/dvld/ram_wre/addr_err=0, phase=0, ram_addr=0.
REQ-018 Reset mid-slot SHALL abandon the slot; after rst release the block SHALL wait for a new start.

Verification
REQ-019 start, then 576 back-to-back mmse_vld -> writes to addresses 0..575, phase 1->2 the cycle after the last write.
REQ-020 In AVG, avg_rd_req at addr 10 and avg_wr_vld in the same cycle -> write to 576 granted, read not granted; read to 10 granted the next cycle, avg_rd_dvld one cycle later.
REQ-021 avg_rd_req at addr 600 in AVG -> no grant, single addr_err pulse.
REQ-022 After 240 averaged writes (576..815) -> phase=3; eq reads to 0, 815 and 816 -> two grants with dvld, one addr_err; eq_done -> phase=0.
REQ-023 start during FILL, and mmse_vld during EQ -> no effect; rst low at FILL write 100 -> all outputs 0, phase 0, restart writes from address 0.
